// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : fetch/decode side bundle for the hazard controller
// Rev 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int N     = 64,
  parameter int CNT_W = 32
);
  logic [31:0]      fetch_instr;
  logic [N-1:0]     fetch_pc;
  logic             reg2loc;
  logic             br_taken;
  logic             pc_write;
  logic [31:0]      ifid_instr;
  logic [N-1:0]     ifid_pc;
  logic             ifid_valid;
  logic             idex_bubble;
  logic [2:0]       flush_vec;
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fetch_instr, fetch_pc, reg2loc, br_taken,
    input  pc_write, ifid_instr, ifid_pc, ifid_valid, idex_bubble,
           flush_vec, hazard, stall_cnt, flush_cnt
  );

  modport slave (
    input  fetch_instr, fetch_pc, reg2loc, br_taken,
    output pc_write, ifid_instr, ifid_pc, ifid_valid, idex_bubble,
           flush_vec, hazard, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : IF/ID register, load-use stall and taken-branch flush
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int N           = 64,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [10:0]      LDUR_OP    = 11'b11111000010;
  localparam logic [7:0]       CBZ_OP     = 8'b10110100;
  localparam logic [4:0]       XZR        = 5'd31;
  localparam logic [2:0]       FLUSH_MASK = 3'((1 << FLUSH_DEPTH) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  generate
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 3) begin : g_bad_flush_depth
      $error("pipe_hazard_ctrl: FLUSH_DEPTH must be in 1..3");
    end
  endgenerate

  logic [31:0]      ifid_instr;
  logic [N-1:0]     ifid_pc;
  logic             ifid_valid;
  logic             idex_ld;
  logic [4:0]       idex_rd;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic             is_ldur;
  logic             rn_used;
  logic [4:0]       rn;
  logic [4:0]       rs2;
  logic             hazard;

  always_comb begin
    is_ldur = (ifid_instr[31:21] == LDUR_OP);
    rn_used = (ifid_instr[31:24] != CBZ_OP);
    rn      = ifid_instr[9:5];
    rs2     = bus.reg2loc ? ifid_instr[4:0] : ifid_instr[20:16];
    hazard  = ifid_valid & idex_ld & (idex_rd != XZR) &
              ((rn_used & (idex_rd == rn)) | (idex_rd == rs2));
  end

  // Branch flush outranks the stall, so the PC is always released on br_taken.
  assign bus.hazard      = hazard;
  assign bus.pc_write    = bus.br_taken | ~hazard;
  assign bus.idex_bubble = bus.br_taken | hazard;
  assign bus.flush_vec   = bus.br_taken ? FLUSH_MASK : 3'b000;
  assign bus.ifid_instr  = ifid_instr;
  assign bus.ifid_pc     = ifid_pc;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
      idex_ld    <= 1'b0;
      idex_rd    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (bus.br_taken) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
      idex_ld    <= 1'b0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end else if (hazard) begin
      // IF/ID holds; the bubble clears the load so the stall self-terminates.
      idex_ld <= 1'b0;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      ifid_instr <= bus.fetch_instr;
      ifid_pc    <= bus.fetch_pc;
      ifid_valid <= 1'b1;
      idex_ld    <= ifid_valid & is_ldur;
      idex_rd    <= ifid_instr[4:0];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed + random checks of two controller instances
// Rev 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic [31:0] fetch_instr = '0;
  logic [63:0] fetch_pc    = '0;
  logic        reg2loc     = 1'b0;
  logic        br_taken    = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  pipe_hazard_ctrl_if #(.N(64), .CNT_W(4))  bus_a ();
  pipe_hazard_ctrl_if #(.N(64), .CNT_W(32)) bus_b ();

  assign bus_a.fetch_instr = fetch_instr;
  assign bus_a.fetch_pc    = fetch_pc;
  assign bus_a.reg2loc     = reg2loc;
  assign bus_a.br_taken    = br_taken;
  assign bus_b.fetch_instr = fetch_instr;
  assign bus_b.fetch_pc    = fetch_pc;
  assign bus_b.reg2loc     = reg2loc;
  assign bus_b.br_taken    = br_taken;

  pipe_hazard_ctrl #(.N(64), .FLUSH_DEPTH(3), .CNT_W(4))  dut_a (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_a));
  pipe_hazard_ctrl #(.N(64), .FLUSH_DEPTH(1), .CNT_W(32)) dut_b (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Reference: instruction memory, bench PC, and an abstract view of the pipe
  logic [31:0] prog [256];
  logic [63:0] pc;
  logic [63:0] br_target;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_ld;
  logic [4:0]  m_rd;
  int          m_stall;
  int          m_flush;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_cbz(logic [31:0] i);
    return i[31:24] == 8'hB4;
  endfunction

  function automatic bit is_ldur(logic [31:0] i);
    return i[31:21] == 11'b11111000010;
  endfunction

  // The instruction in ID needs a register that a live load in EX has not yet returned
  function automatic bit model_hazard();
    logic [4:0] reads [$];
    if (!m_valid || !m_ld || m_rd == 5'd31) return 1'b0;
    if (!is_cbz(m_instr)) reads.push_back(m_instr[9:5]);
    reads.push_back(is_cbz(m_instr) ? m_instr[4:0] : m_instr[20:16]);
    foreach (reads[k]) if (reads[k] == m_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] sat4(int v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic model_clear();
    m_instr = '0; m_pc = '0; m_valid = 0; m_ld = 0; m_rd = '0;
    m_stall = 0;  m_flush = 0; pc = '0;
  endtask

  task automatic check_comb();
    bit hz;
    hz = model_hazard();
    check("hazard_a",   64'(bus_a.hazard),      64'(hz));
    check("hazard_b",   64'(bus_b.hazard),      64'(hz));
    check("pc_write",   64'(bus_a.pc_write),    64'(br_taken | !hz));
    check("bubble",     64'(bus_b.idex_bubble), 64'(br_taken | hz));
    check("flush_vec_a", 64'(bus_a.flush_vec),  br_taken ? 64'd7 : 64'd0);
    check("flush_vec_b", 64'(bus_b.flush_vec),  br_taken ? 64'd1 : 64'd0);
  endtask

  task automatic check_regs();
    check("ifid_instr", 64'(bus_a.ifid_instr), 64'(m_instr));
    check("ifid_pc",    bus_b.ifid_pc,         m_pc);
    check("ifid_valid", 64'(bus_a.ifid_valid), 64'(m_valid));
    check("stall_a",    64'(bus_a.stall_cnt),  sat4(m_stall));
    check("stall_b",    64'(bus_b.stall_cnt),  64'(m_stall));
    check("flush_a",    64'(bus_a.flush_cnt),  sat4(m_flush));
    check("flush_b",    64'(bus_b.flush_cnt),  64'(m_flush));
  endtask

  task automatic drive(bit br);
    br_taken    = br;
    fetch_instr = prog[pc[9:2]];
    fetch_pc    = pc;
    reg2loc     = is_cbz(m_instr);
    #1;
  endtask

  task automatic tick();
    bit br, hz;
    br = br_taken;
    hz = model_hazard();
    @(posedge CLOCK_50);
    #1;
    if (br) begin
      m_flush++;
      m_instr = '0; m_pc = '0; m_valid = 0; m_ld = 0;
      pc = br_target;
    end else if (hz) begin
      m_stall++;
      m_ld = 0;
    end else begin
      m_ld    = m_valid && is_ldur(m_instr);
      m_rd    = m_instr[4:0];
      m_instr = fetch_instr;
      m_pc    = fetch_pc;
      m_valid = 1;
      pc      = pc + 64'd4;
    end
    check_regs();
  endtask

  task automatic step(bit br);
    drive(br);
    check_comb();
    tick();
  endtask

  task automatic do_reset();
    br_taken = 0;
    reset    = 0;
    #1;
    model_clear();
    check_comb();
    check_regs();
    @(posedge CLOCK_50);
    #1;
    reset = 1;
  endtask

  task automatic clear_prog();
    foreach (prog[k]) prog[k] = '0;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 3)      return {11'b11111000010, 9'($urandom), 2'b00, rreg(), rreg()};
    else if (k <= 6) return {11'b10001011000, rreg(), 6'b0, rreg(), rreg()};
    else if (k == 7) return {8'hB4, 19'($urandom), rreg()};
    else             return $urandom;
  endfunction

  initial begin
    br_target = 64'h40;
    clear_prog();
    #2;
    do_reset();

    // LDUR X1,[X2] then ADD X3,X3,X1: one-cycle load-use stall
    prog[0] = 32'hF8400041;
    prog[1] = 32'h8B010063;
    step(0);
    step(0);
    drive(0);
    check_comb();
    check("lu_hazard",   64'(bus_a.hazard),      64'd1);
    check("lu_pc_write", 64'(bus_a.pc_write),    64'd0);
    check("lu_bubble",   64'(bus_a.idex_bubble), 64'd1);
    tick();
    check("lu_pc_hold",  bus_a.ifid_pc,          64'd4);
    drive(0);
    check_comb();
    check("lu_drop",     64'(bus_a.hazard),      64'd0);
    check("lu_stall1",   64'(bus_b.stall_cnt),   64'd1);
    tick();
    repeat (3) step(0);

    // X31 destination never stalls
    do_reset();
    clear_prog();
    prog[0] = 32'hF840005F;
    prog[1] = 32'h8B1F0063;
    repeat (5) step(0);
    check("xzr_stall", 64'(bus_b.stall_cnt), 64'd0);

    // CBZ reads Rt through reg2loc, ignores Rn
    do_reset();
    clear_prog();
    prog[0] = 32'hF8400045;
    prog[1] = 32'hB4000045;
    step(0);
    step(0);
    drive(0);
    check_comb();
    check("cbz_hazard", 64'(bus_a.hazard), 64'd1);
    tick();
    do_reset();
    clear_prog();
    prog[0] = 32'hF8400045;
    prog[1] = 32'hB40000A6;
    step(0);
    step(0);
    drive(0);
    check_comb();
    check("cbz_rn_ignored", 64'(bus_a.hazard), 64'd0);
    tick();

    // Taken branch flush
    do_reset();
    clear_prog();
    step(0);
    step(0);
    drive(1);
    check_comb();
    check("br_vec3", 64'(bus_a.flush_vec), 64'd7);
    check("br_vec1", 64'(bus_b.flush_vec), 64'd1);
    tick();
    check("br_valid", 64'(bus_a.ifid_valid), 64'd0);
    check("br_instr", 64'(bus_a.ifid_instr), 64'd0);
    check("br_cnt",   64'(bus_b.flush_cnt),  64'd1);
    step(0);

    // Branch coincident with load-use
    do_reset();
    clear_prog();
    prog[0] = 32'hF8400041;
    prog[1] = 32'h8B010063;
    step(0);
    step(0);
    drive(1);
    check_comb();
    check("brhz_pc_write", 64'(bus_a.pc_write), 64'd1);
    tick();
    check("brhz_stall", 64'(bus_b.stall_cnt), 64'd0);
    check("brhz_flush", 64'(bus_b.flush_cnt), 64'd1);
    step(0);

    // 20 load-use pairs: 4-bit counter saturates at 15
    do_reset();
    clear_prog();
    for (int i = 0; i < 20; i++) begin
      prog[2*i]   = 32'hF8400041;
      prog[2*i+1] = 32'h8B010063;
    end
    repeat (66) step(0);
    check("sat_a", 64'(bus_a.stall_cnt), 64'd15);
    check("sat_b", 64'(bus_b.stall_cnt), 64'd20);

    // Reset asserted mid-stall clears everything before the next edge
    prog[0] = 32'hF8400041;
    prog[1] = 32'h8B010063;
    br_target = 64'h0;
    step(1);
    step(0);
    step(0);
    drive(0);
    check("pre_rst_hazard", 64'(bus_a.hazard), 64'd1);
    #1;
    reset = 0;
    #1;
    check("rst_hazard",   64'(bus_a.hazard),     64'd0);
    check("rst_pc_write", 64'(bus_a.pc_write),   64'd1);
    check("rst_stall_a",  64'(bus_a.stall_cnt),  64'd0);
    check("rst_flush_b",  64'(bus_b.flush_cnt),  64'd0);
    check("rst_valid",    64'(bus_b.ifid_valid), 64'd0);
    check("rst_instr",    64'(bus_b.ifid_instr), 64'd0);
    do_reset();

    // Randomised program with random taken branches
    foreach (prog[k]) prog[k] = rand_instr();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      br_target = {52'd0, 8'($urandom_range(0, 255)), 2'b00};
      step($urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised successor to the bare 11-bit IF/ID opcode flop in the pipelined LEGv8 top. It owns the full IF/ID register (instruction, PC, valid) and a shadow of ID/EX load metadata. It detects load-use hazards and stalls fetch. It flushes younger stages on a taken branch, with configurable flush depth, and keeps saturating stall/flush performance counters. It sits between imem/PC logic and controller/datapath decode.

Parameters:
N, 64, datapath/PC width
FLUSH_DEPTH, 3, number of younger pipeline registers flushed on taken branch (legal 1..3: IF/ID, ID/EX, EX/MEM)
CNT_W, 32, width of performance counters

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
fetch_instr  input  32  instruction word from imem (IF stage)
fetch_pc  input  N  PC of fetch_instr
reg2loc  input  1  controller decode of ifid_instr; 1 = second source is instr[4:0], 0 = instr[20:16]
br_taken  input  1  branch resolved taken in MEM stage this cycle
pc_write  output  1  PC register enable (0 = hold PC)
ifid_instr  output  32  registered IF/ID instruction
ifid_pc  output  N  registered IF/ID PC
ifid_valid  output  1  IF/ID holds a live instruction
idex_bubble  output  1  force ID/EX control fields to zero this edge
flush_vec  output  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM clear request (combinational)
hazard  output  1  load-use hazard detected (combinational)
stall_cnt  output  CNT_W  cycles stalled by hazard
flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
- Reset (reset=0, async): ifid_instr=0, ifid_pc=0, ifid_valid=0, internal idex_ld=0, idex_rd=0, both counters=0. Outputs follow combinationally: hazard=0, pc_write=1, idex_bubble=0, flush_vec=0.
- LDUR decode: ifid_instr[31:21]==11'b11111000010. CBZ decode: ifid_instr[31:24]==8'b10110100.
- Source regs of ID instr: rn=instr[9:5], used unless CBZ. rs2=reg2loc?instr[4:0]:instr[20:16].
- hazard = ifid_valid & idex_ld & (idex_rd!=31) & ((rn_used & idex_rd==rn) | idex_rd==rs2). Combinational, same cycle.
- Priority: br_taken > hazard > normal.
- br_taken: flush_vec[k]=1 for k<FLUSH_DEPTH, else 0. pc_write=1, idex_bubble=1. Next edge: ifid_valid=0, ifid_instr=0, ifid_pc=0, idex_ld=0. flush_cnt+1. Stall is ignored and stall_cnt is not incremented.
- hazard & ~br_taken: pc_write=0. IF/ID holds all three fields. idex_bubble=1, idex_ld<=0. stall_cnt+1.
- Normal: pc_write=1. IF/ID <= {fetch_instr, fetch_pc, 1}. idex_ld<=ifid_valid & LDUR, idex_rd<=ifid_instr[4:0].
- Load-use stall lasts exactly 1 cycle: after the bubble idex_ld=0, so hazard drops.
- First cycle after reset release: IF/ID loads fetch and ifid_valid=1 on the first edge.
- Counters saturate at all-ones and do not wrap.
- X31 (XZR) as destination never triggers hazard.
- Reset asserted mid-stall or mid-flush: all state is cleared immediately. No pending stall or flush survives.
- FLUSH_DEPTH outside 1..3: elaboration error.

Test Plan:
- Reset then fetch 0xF8400041 (LDUR X1,[X2]) at pc=0, then 0x8B010063 (ADD X3,X3,X1) at pc=4 -> ADD cycle in ID: hazard=1, pc_write=0, idex_bubble=1, ifid_pc holds 4; next cycle hazard=0, stall_cnt=1.
- LDUR X31 followed by ADD using X31 -> hazard stays 0, stall_cnt=0.
- LDUR X5 then CBZ X5 (reg2loc=1, 0xB4000045) -> hazard=1. LDUR X5 then CBZ X6 whose Rn field=5 -> hazard=0.
- br_taken pulse with FLUSH_DEPTH=3 -> flush_vec=3'b111, next edge ifid_valid=0 and ifid_instr=0, flush_cnt=1. Repeat with FLUSH_DEPTH=1 -> flush_vec=3'b001.
- br_taken coincident with hazard -> pc_write=1, flush taken, stall_cnt unchanged, flush_cnt+1.
- CNT_W=4, 20 consecutive load-use pairs -> stall_cnt saturates at 15. Assert reset mid-stall -> all counters/outputs 0 asynchronously, before the clock edge.
